// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// SCL is push-pull; SDA is open-drain (drives 0 or releases to the pull-up).
module i2c_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    output logic [7:0] data_rd,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       q, q_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, sh_n;
    logic [7:0]       wr_q, wr_n;
    logic             rw_q, rw_n;
    logic             ack_q, ack_n;
    logic             sda_low, sda_low_n;
    logic [1:0]       sync;
    logic             busy_n, done_n, ack_err_n, scl_n;
    logic [7:0]       data_rd_n;
    logic             tick, sample, slot_end, sda_in;

    // Open-drain SDA: only ever pull low, otherwise leave to the pull-up
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sync[1];

    // State, counters, datapath and registered bus/host outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            q       <= 2'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            wr_q    <= 8'd0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
            sda_low <= 1'b0;
            sync    <= 2'b11;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            data_rd <= 8'd0;
            scl     <= 1'b1;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            q       <= q_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            wr_q    <= wr_n;
            rw_q    <= rw_n;
            ack_q   <= ack_n;
            sda_low <= sda_low_n;
            sync    <= {sync[0], sda};
            busy    <= busy_n;
            done    <= done_n;
            ack_err <= ack_err_n;
            data_rd <= data_rd_n;
            scl     <= scl_n;
        end
    end

    // Next-state, quarter sequencing and next bus levels
    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        q_n       = q;
        bit_n     = bit_cnt;
        sh_n      = shreg;
        wr_n      = wr_q;
        rw_n      = rw_q;
        ack_n     = ack_q;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = ack_err;
        data_rd_n = data_rd;
        scl_n     = 1'b1;
        sda_low_n = 1'b0;

        tick     = (state != ST_IDLE) && (div_cnt == DIV_LAST);
        sample   = tick && (q == 2'd2);
        slot_end = tick && (q == 2'd3);

        if (state != ST_IDLE) begin
            div_n = tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                q_n = q + 2'd1;
            end
        end

        case (state)
            ST_IDLE: begin
                // A start in the done cycle is ignored; the next cycle is the earliest accept
                if (start && !done) begin
                    sh_n      = {addr, rw};
                    rw_n      = rw;
                    wr_n      = data_wr;
                    bit_n     = 3'd7;
                    busy_n    = 1'b1;
                    ack_err_n = 1'b0;
                    state_n   = ST_START;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    bit_n   = 3'd7;
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (slot_end) begin
                    sh_n = {shreg[6:0], 1'b0};
                    if (bit_cnt == 3'd0) begin
                        state_n = ST_ACK1;
                    end else begin
                        bit_n = bit_cnt - 3'd1;
                    end
                end
            end
            ST_ACK1: begin
                if (sample) begin
                    ack_n = sda_in;
                end
                if (slot_end) begin
                    if (ack_q) begin
                        ack_err_n = 1'b1;
                        state_n   = ST_STOP;
                    end else begin
                        bit_n   = 3'd7;
                        state_n = ST_DATA;
                        if (!rw_q) begin
                            sh_n = wr_q;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (sample && rw_q) begin
                    sh_n = {shreg[6:0], sda_in};
                end
                if (slot_end) begin
                    if (!rw_q) begin
                        sh_n = {shreg[6:0], 1'b0};
                    end
                    if (bit_cnt == 3'd0) begin
                        state_n = ST_ACK2;
                    end else begin
                        bit_n = bit_cnt - 3'd1;
                    end
                end
            end
            ST_ACK2: begin
                // On a read the master NACKs by leaving SDA released; the sample is unused
                if (sample) begin
                    ack_n = sda_in;
                end
                if (slot_end) begin
                    if (!rw_q && ack_q) begin
                        ack_err_n = 1'b1;
                    end
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                    if (rw_q && !ack_err) begin
                        data_rd_n = shreg;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Bus levels follow the upcoming state/quarter so they are registered in step with it
        case (state_n)
            ST_START: sda_low_n = q_n[1];
            ST_ADDR: begin
                scl_n     = q_n[1];
                sda_low_n = ~sh_n[7];
            end
            ST_DATA: begin
                scl_n     = q_n[1];
                sda_low_n = ~rw_n & ~sh_n[7];
            end
            ST_ACK1, ST_ACK2: scl_n = q_n[1];
            ST_STOP: begin
                scl_n     = q_n[1];
                sda_low_n = (q_n != 2'd3);
            end
            default: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural I2C slave, scoreboard on done, bus protocol monitor.
module tb_i2c_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam logic [6:0]  SLV_ADDR = 7'h57;
    localparam logic [7:0]  SLV_BYTE = 8'hCD;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data_wr;
    wire  [7:0] data_rd;
    wire        busy, done, ack_err, scl;
    wire        sda;

    logic slv_drive = 1'b0;
    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard entries pushed at accept, popped when done pulses
    typedef struct {
        logic       ack_err;
        logic [7:0] data_rd;
        int         latency;
        int         rises;
        int         acc_cyc;
    } exp_t;
    exp_t       sb_q[$];
    logic [7:0] exp_rd = 8'h00;

    // Slave model state
    typedef enum {S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK} sph_t;
    sph_t       ph = S_IDLE;
    int         bitn = 0;
    logic [7:0] sh = 8'h00, rsh = 8'h00;
    logic       s_rw = 1'b0;
    logic       s_pscl = 1'b1, s_psda = 1'b1;
    logic [7:0] data_in = 8'h00;
    int         wr_count = 0;
    logic       master_ack_bit = 1'b0;

    // I2C slave at address 0x57 holding byte 0xCD; reacts to bus edges seen on the falling clock
    always @(negedge clk) begin
        if (s_pscl && scl && s_psda && !sda) begin
            ph = S_ADDR; bitn = 0; sh = 8'h00; slv_drive <= 1'b0;
        end else if (s_pscl && scl && !s_psda && sda) begin
            ph = S_IDLE; slv_drive <= 1'b0;
        end else if (!s_pscl && scl) begin
            case (ph)
                S_ADDR, S_WDATA: begin sh = {sh[6:0], sda}; bitn++; end
                S_RDATA:         bitn++;
                S_RACK:          master_ack_bit = sda;
                default: ;
            endcase
        end else if (s_pscl && !scl) begin
            case (ph)
                S_ADDR: if (bitn == 8) begin
                    if (sh[7:1] == SLV_ADDR) begin
                        ph = S_AACK; s_rw = sh[0]; slv_drive <= 1'b1;
                    end else begin
                        ph = S_IDLE;
                    end
                end
                S_AACK: if (s_rw) begin
                    ph = S_RDATA; bitn = 0; rsh = SLV_BYTE;
                    slv_drive <= !rsh[7]; rsh = {rsh[6:0], 1'b0};
                end else begin
                    ph = S_WDATA; bitn = 0; sh = 8'h00; slv_drive <= 1'b0;
                end
                S_WDATA: if (bitn == 8) begin
                    data_in = sh; wr_count++; ph = S_WACK; slv_drive <= 1'b1;
                end
                S_WACK: begin ph = S_IDLE; slv_drive <= 1'b0; end
                S_RDATA: if (bitn == 8) begin
                    ph = S_RACK; slv_drive <= 1'b0;
                end else begin
                    slv_drive <= !rsh[7]; rsh = {rsh[6:0], 1'b0};
                end
                S_RACK: ph = S_IDLE;
                default: ;
            endcase
        end
        s_pscl = scl;
        s_psda = sda;
    end

    // Protocol monitor and scoreboard checker
    logic p_scl = 1'b1, p_sda = 1'b1;
    int   rises = 0, starts = 0, stops = 0;
    int   hi_len = 0, lo_len = 0;
    bit   hi_ok = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (p_scl && scl && (sda != p_sda)) begin
            if (sda) stops++;
            else     starts++;
        end
        if (scl != p_scl) begin
            if (scl) begin
                if (busy) chk("scl_low_time", 32'(lo_len), 32'(2 * CLK_DIV));
                rises++;
                hi_len = 1;
                hi_ok  = busy;
            end else begin
                if (hi_ok) chk("scl_high_time", 32'(hi_len), 32'(2 * CLK_DIV));
                lo_len = 1;
            end
        end else begin
            hi_len++;
            lo_len++;
            if (!busy) hi_ok = 1'b0;
        end
        p_scl = scl;
        p_sda = sda;

        if (done) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_latency", 32'(cyc - e.acc_cyc), 32'(e.latency));
                chk("ack_err",      32'(ack_err),         32'(e.ack_err));
                chk("data_rd",      32'(data_rd),         32'(e.data_rd));
                chk("busy_at_done", 32'(busy),            32'd0);
                chk("scl_rises",    32'(rises),           32'(e.rises));
                chk("start_conds",  32'(starts),          32'd1);
                chk("stop_conds",   32'(stops),           32'd1);
            end
        end
    end

    // Caller positions this away from the rising edge; start is sampled on the next edge
    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic exp_ack, input int exp_lat, input int exp_rises);
        exp_t x;
        addr = a; rw = r; data_wr = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (r && !exp_ack) exp_rd = SLV_BYTE;
        x.ack_err = exp_ack;
        x.data_rd = exp_rd;
        x.latency = exp_lat;
        x.rises   = exp_rises;
        x.acc_cyc = cyc;
        sb_q.push_back(x);
        rises = 0; starts = 0; stops = 0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; data_wr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl",     32'(scl),     32'd1);
        chk("rst_sda",     32'(sda),     32'd1);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_data_rd", 32'(data_rd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write 0xA5
        issue(SLV_ADDR, 1'b0, 8'hA5, 1'b0, 80 * CLK_DIV, 19);
        wait_done(100 * CLK_DIV);
        chk("slave_data_in_a5", 32'(data_in), 32'hA5);
        chk("slave_wr_count_1", 32'(wr_count), 32'd1);

        // Read 0xCD
        @(negedge clk);
        issue(SLV_ADDR, 1'b1, 8'h00, 1'b0, 80 * CLK_DIV, 19);
        wait_done(100 * CLK_DIV);
        chk("master_nack_read", 32'(master_ack_bit), 32'd1);

        // Wrong address
        @(negedge clk);
        issue(7'h23, 1'b0, 8'h5A, 1'b1, 44 * CLK_DIV, 10);
        wait_done(100 * CLK_DIV);
        chk("slave_wr_count_nack", 32'(wr_count), 32'd1);
        repeat (5) @(negedge clk);
        chk("ack_err_held", 32'(ack_err), 32'd1);

        // Busy protection
        issue(SLV_ADDR, 1'b0, 8'hA5, 1'b0, 80 * CLK_DIV, 19);
        repeat (25 * CLK_DIV) @(negedge clk);
        addr = SLV_ADDR; rw = 1'b0; data_wr = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_during_ignored_start", 32'(busy), 32'd1);
        wait_done(100 * CLK_DIV);
        chk("slave_data_in_first", 32'(data_in), 32'hA5);
        chk("slave_wr_count_2", 32'(wr_count), 32'd2);
        addr = 7'h23; rw = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("start_with_done_ignored", 32'(busy), 32'd0);
        master_ack_bit = 1'b0;
        issue(SLV_ADDR, 1'b1, 8'h00, 1'b0, 80 * CLK_DIV, 19);
        wait_done(100 * CLK_DIV);
        chk("master_nack_read2", 32'(master_ack_bit), 32'd1);

        // Reset after three address bits
        @(negedge clk);
        issue(SLV_ADDR, 1'b0, 8'h77, 1'b0, 80 * CLK_DIV, 19);
        repeat (16 * CLK_DIV + 1) @(posedge clk);
        #1;
        chk("scl_low_pre_reset", 32'(scl), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_scl",     32'(scl),     32'd1);
        chk("midrst_sda",     32'(sda),     32'd1);
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_data_rd", 32'(data_rd), 32'd0);
        sb_q.delete();
        exp_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_stop_after_reset", 32'(stops), 32'd0);
        chk("idle_after_reset",    32'(busy),  32'd0);

        // Write after reset
        issue(SLV_ADDR, 1'b0, 8'h5A, 1'b0, 80 * CLK_DIV, 19);
        wait_done(100 * CLK_DIV);
        chk("slave_data_in_5a", 32'(data_in), 32'h5A);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
